render_queue: RTL and testbench
===============================

RENDER_QUEUE -- requirements
Module: render_queue

Interface
REQ-001 Parameter DEPTH, default 16, command FIFO depth in entries (power of two, 2..64).
REQ-002 Parameter ACK_TIMEOUT, default 8, cycles allowed after a render pulse for busy to rise.
REQ-003 clk_100M  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  upstream game logic presents a draw command.
REQ-006 cmd_ready  output  1  queue can accept a command this cycle.
REQ-007 cmd_sprite  input  3  sprite ID 0-7.
REQ-008 cmd_x  input  6  grid X, legal 0-39.
REQ-009 cmd_y  input  5  grid Y, legal 0-29.
REQ-010 sprite_id  output  3  to graphics engine sprite_id.
REQ-011 blk_x  output  6  to graphics engine blk_x.
REQ-012 blk_y  output  5  to graphics engine blk_y.
REQ-013 render  output  1  to graphics engine render trigger.
REQ-014 busy  input  1  from graphics engine; high while it works.
REQ-015 pending  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-016 drop_err  output  1  sticky: a command was discarded or a render went unacknowledged.

Function
REQ-017 Command accepted on a rising edge where cmd_valid and cmd_ready are both high.
REQ-018 cmd_ready = (pending < DEPTH); a pop in the same cycle does not raise cmd_ready while full.
REQ-019 Accepted command with cmd_x > 39 or cmd_y > 29 is not enqueued; drop_err sets on the next edge.
REQ-020 FIFO read/write pointers wrap modulo DEPTH; simultaneous push and pop leave pending unchanged.
REQ-021 FSM states: IDLE, ISSUE, ACK, DONE.
REQ-022 IDLE -> ISSUE when pending > 0 and busy = 0; head popped and loaded into sprite_id/blk_x/blk_y on that edge.
REQ-023 render is high exactly one cycle, only in ISSUE; ISSUE -> ACK unconditionally.
REQ-024 ACK -> DONE when busy = 1 (busy sampled in ISSUE also counts); timeout counter starts at ISSUE.
REQ-025 ACK -> IDLE, setting drop_err, if busy not seen within ACK_TIMEOUT cycles of the render cycle.
REQ-026 DONE -> IDLE when busy = 0.
REQ-027 sprite_id, blk_x, blk_y are registered and do not change from ISSUE entry until the next ISSUE.
REQ-028 Latency: push into empty queue with FSM in IDLE and busy low -> render high in the cycle after the accepting edge.
REQ-029 Back-to-back: next render no earlier than the cycle after DONE -> IDLE, i.e. at least one idle cycle between pulses.
REQ-030 drop_err clears only on reset.

Reset
REQ-031 On reset: FSM IDLE, FIFO empty, pending 0, render 0, sprite_id/blk_x/blk_y 0, drop_err 0, timeout counter 0.
REQ-032 cmd_ready is 0 while reset is high and 1 on the first cycle after it deasserts.
REQ-033 Reset mid-operation does not abort the engine; after reset no render issues until busy = 0 (REQ-022).

Structure
REQ-034 Package render_pkg holds GRID_W = 40, GRID_H = 30, SPRITE_W = 3, X_W = 6, Y_W = 5, the FSM state enum and the draw-command struct {sprite, x, y}.
REQ-035 FIFO storage and pointers live in one sub-module, cmd_fifo, parameterised by DEPTH and the command struct; the FSM stays in render_queue.

Verification
REQ-036 Single command (sprite 5, x 30, y 8); engine model raises busy 1 cycle after render and holds it 10 cycles -> one render pulse, outputs 5/30/8 stable until the next issue, pending back to 0.
REQ-037 Push 16 commands with busy held high -> cmd_ready low after the 16th, pending = 16, no render; 17th held -> not accepted.
REQ-038 Push (2, 40, 0) then (1, 0, 30) -> neither enqueued, drop_err = 1, pending = 0, no render.
REQ-039 Engine model never raises busy -> ACK exits after 8 cycles, drop_err = 1, next queued command issues.
REQ-040 Reset asserted during DONE with 3 queued and busy high -> pending 0, render 0; busy then falls, new push -> render one cycle after acceptance.

Source files
------------

// File: rtl/render_pkg.sv
// Shared types and grid constants for the sprite render command queue.
// The draw command struct is the unit stored in the FIFO and handed to the engine.
package render_pkg;

    localparam int GRID_W   = 40;
    localparam int GRID_H   = 30;
    localparam int SPRITE_W = 3;
    localparam int X_W      = 6;
    localparam int Y_W      = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2,
        DONE  = 2'd3
    } rq_state_e;

    typedef struct packed {
        logic [SPRITE_W-1:0] sprite;
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
    } draw_cmd_t;

    function automatic logic in_grid(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (x < X_W'(GRID_W)) && (y < Y_W'(GRID_H));
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Power-of-two circular command FIFO; pointers wrap naturally at DEPTH.
// Callers gate push on not-full and pop on not-empty.
module cmd_fifo
    import render_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter type cmd_t = draw_cmd_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  cmd_t                   push_data,
    input  logic                   pop,
    output cmd_t                   pop_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: the storage array is deliberately not reset; count and the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/render_queue.sv
// Buffers draw commands from game logic and feeds them one at a time to the
// graphics engine, handshaking on busy and flagging drops and lost renders.
module render_queue
    import render_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                   clk_100M,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [SPRITE_W-1:0]    cmd_sprite,
    input  logic [X_W-1:0]         cmd_x,
    input  logic [Y_W-1:0]         cmd_y,
    output logic [SPRITE_W-1:0]    sprite_id,
    output logic [X_W-1:0]         blk_x,
    output logic [Y_W-1:0]         blk_y,
    output logic                   render,
    input  logic                   busy,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   drop_err
);

    localparam int PEND_W = $clog2(DEPTH) + 1;
    localparam int CNT_W  = $clog2(ACK_TIMEOUT + 1);
    localparam logic [PEND_W-1:0] FULL_LEVEL = PEND_W'(DEPTH);
    localparam logic [CNT_W-1:0]  TMO_LIMIT  = CNT_W'(ACK_TIMEOUT);

    rq_state_e        state, state_next;
    draw_cmd_t        in_cmd, head;
    logic             accept, push, pop, bad_cmd, timeout;
    logic             busy_seen;
    logic [CNT_W-1:0] tmo_cnt;

    assign in_cmd    = '{sprite: cmd_sprite, x: cmd_x, y: cmd_y};
    assign cmd_ready = !reset && (pending < FULL_LEVEL);
    assign accept    = cmd_valid && cmd_ready;
    assign push      = accept && in_grid(cmd_x, cmd_y);
    assign bad_cmd   = accept && !in_grid(cmd_x, cmd_y);
    assign render    = (state == ISSUE);

    cmd_fifo #(
        .DEPTH (DEPTH),
        .cmd_t (draw_cmd_t)
    ) u_fifo (
        .clk       (clk_100M),
        .reset     (reset),
        .push      (push),
        .push_data (in_cmd),
        .pop       (pop),
        .pop_data  (head),
        .count     (pending)
    );

    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if ((pending != '0) && !busy) begin
                    state_next = ISSUE;
                    pop        = 1'b1;
                end
            end
            ISSUE: state_next = ACK;
            ACK: begin
                if (busy || busy_seen) begin
                    state_next = DONE;
                end else if (tmo_cnt >= TMO_LIMIT) begin
                    state_next = IDLE;
                    timeout    = 1'b1;
                end
            end
            DONE: begin
                if (!busy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_100M) begin
        if (reset) begin
            state     <= IDLE;
            sprite_id <= '0;
            blk_x     <= '0;
            blk_y     <= '0;
            tmo_cnt   <= '0;
            busy_seen <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            state    <= state_next;
            drop_err <= drop_err | bad_cmd | timeout;
            if (pop) begin
                sprite_id <= head.sprite;
                blk_x     <= head.x;
                blk_y     <= head.y;
            end
            // Counts from the render cycle; saturates so it cannot wrap in DONE.
            if (pop) begin
                tmo_cnt <= '0;
            end else if ((state != IDLE) && (tmo_cnt < TMO_LIMIT)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (state == ISSUE) begin
                busy_seen <= busy;
            end else if (state == IDLE) begin
                busy_seen <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_render_queue.sv
// Scenario bench for render_queue: a scoreboard of expected draw commands is
// checked at every render pulse, with an optional engine model driving busy.
module tb_render_queue;
    import render_pkg::*;

    localparam int DEPTH = 16;

    logic                   clk_100M;
    logic                   reset;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [SPRITE_W-1:0]    cmd_sprite;
    logic [X_W-1:0]         cmd_x;
    logic [Y_W-1:0]         cmd_y;
    logic [SPRITE_W-1:0]    sprite_id;
    logic [X_W-1:0]         blk_x;
    logic [Y_W-1:0]         blk_y;
    logic                   render;
    logic                   busy;
    logic [$clog2(DEPTH):0] pending;
    logic                   drop_err;

    logic force_busy;
    logic model_busy;
    bit   eng_on;

    int total;
    int bad;
    int cyc;
    int render_count;
    int last_render_cyc;
    int prev_render_cyc;
    int min_gap;
    bit have_prev;
    int drop_rise_cyc;
    bit drop_prev;
    int gap;

    draw_cmd_t sb[$];
    draw_cmd_t exp_hold;

    assign busy = force_busy | model_busy;

    render_queue #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk_100M   (clk_100M),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_sprite (cmd_sprite),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .sprite_id  (sprite_id),
        .blk_x      (blk_x),
        .blk_y      (blk_y),
        .render     (render),
        .busy       (busy),
        .pending    (pending),
        .drop_err   (drop_err)
    );

    initial begin
        clk_100M = 1'b0;
        forever #5 clk_100M = ~clk_100M;
    end

    always @(posedge clk_100M) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Engine model: busy rises the cycle after a render and holds for 10 cycles.
    initial begin
        model_busy = 1'b0;
        forever begin
            @(negedge clk_100M);
            if (eng_on && render && !reset) begin
                @(posedge clk_100M);
                #1 model_busy = 1'b1;
                repeat (10) @(posedge clk_100M);
                #1 model_busy = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on each render and checks the held outputs every cycle.
    always @(negedge clk_100M) begin
        if (reset) begin
            exp_hold  = '0;
            drop_prev = 1'b0;
        end else begin
            if (render) begin
                render_count++;
                if (have_prev) begin
                    gap = cyc - last_render_cyc;
                    if (gap < min_gap) min_gap = gap;
                end
                prev_render_cyc = last_render_cyc;
                last_render_cyc = cyc;
                have_prev       = 1'b1;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_render: cycle %0d got %h with empty scoreboard", cyc,
                             {sprite_id, blk_x, blk_y});
                end else begin
                    exp_hold = sb.pop_front();
                end
            end
            total++;
            if ({sprite_id, blk_x, blk_y} !== exp_hold) begin
                bad++;
                $display("FAIL engine_outputs: cycle %0d got s=%0d x=%0d y=%0d want s=%0d x=%0d y=%0d",
                         cyc, sprite_id, blk_x, blk_y, exp_hold.sprite, exp_hold.x, exp_hold.y);
            end
            if (drop_err && !drop_prev) drop_rise_cyc = cyc;
            drop_prev = drop_err;
        end
    end

    function automatic bit legal(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (int'(x) < 40) && (int'(y) < 30);
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge (or budget expiry).
    task automatic push_cmd(input logic [2:0] s, input logic [5:0] x, input logic [4:0] y,
                            input int budget, output bit ok);
        ok         = 1'b0;
        cmd_valid  = 1'b1;
        cmd_sprite = s;
        cmd_x      = x;
        cmd_y      = y;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_100M);
            if (cmd_ready) ok = 1'b1;
            @(posedge clk_100M);
            #1;
        end
        cmd_valid = 1'b0;
        if (ok && legal(x, y)) sb.push_back('{sprite: s, x: x, y: y});
    endtask

    task automatic do_push(input logic [2:0] s, input logic [5:0] x, input logic [4:0] y);
        bit ok;
        push_cmd(s, x, y, 40, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL push_accept: cmd (%0d,%0d,%0d) accepted=%0d want 1", s, x, y, ok);
        end
    endtask

    task automatic wait_renders(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (render_count < target && n < budget) begin
            @(posedge clk_100M);
            #1;
            n++;
        end
        total++;
        if (render_count < target) begin
            bad++;
            $display("FAIL %s: renders=%0d want %0d", name, render_count, target);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk_100M);
        #1;
    endtask

    task automatic apply_reset(input int n);
        @(posedge clk_100M);
        #1 reset = 1'b1;
        repeat (n) @(posedge clk_100M);
        #1 reset = 1'b0;
        sb.delete();
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk_100M);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk_100M);
        #1;
        total++;
        if (cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_in_reset: got %b want 0", cmd_ready);
        end
        reset = 1'b0;
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset: got %b want 1", cmd_ready);
        end
        total++;
        if ({pending, render, drop_err, sprite_id, blk_x, blk_y} !== '0) begin
            bad++;
            $display("FAIL reset_state: pending=%0d render=%b drop=%b s=%0d x=%0d y=%0d want all 0",
                     pending, render, drop_err, sprite_id, blk_x, blk_y);
        end
    endtask

    task automatic test_single();
        int base;
        eng_on = 1'b1;
        base   = render_count;
        do_push(3'd5, 6'd30, 5'd8);
        total++;
        if (render !== 1'b0 || pending !== 5'd1) begin
            bad++;
            $display("FAIL single_pre: render=%b pending=%0d want 0/1", render, pending);
        end
        @(posedge clk_100M);
        #1;
        total++;
        if (render !== 1'b1 || pending !== 5'd0) begin
            bad++;
            $display("FAIL single_latency: render=%b pending=%0d want 1/0", render, pending);
        end
        settle(20);
        total++;
        if (render_count - base !== 1 || pending !== 5'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_done: renders=%0d pending=%0d busy=%b want 1/0/0",
                     render_count - base, pending, busy);
        end
        total++;
        if (sprite_id !== 3'd5 || blk_x !== 6'd30 || blk_y !== 5'd8) begin
            bad++;
            $display("FAIL single_hold: s=%0d x=%0d y=%0d want 5/30/8", sprite_id, blk_x, blk_y);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        eng_on    = 1'b1;
        base      = render_count;
        have_prev = 1'b0;
        min_gap   = 1000;
        do_push(3'd7, 6'd1, 5'd2);
        do_push(3'd0, 6'd39, 5'd0);
        do_push(3'd4, 6'd20, 5'd29);
        wait_renders(base + 3, 100, "b2b_renders");
        settle(20);
        total++;
        if (min_gap !== 13) begin
            bad++;
            $display("FAIL b2b_gap: min render spacing=%0d want 13", min_gap);
        end
        total++;
        if (pending !== 5'd0 || drop_err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: pending=%0d drop=%b want 0/0", pending, drop_err);
        end
    endtask

    task automatic test_illegal();
        int base;
        eng_on = 1'b1;
        apply_reset(2);
        base = render_count;
        total++;
        if (drop_err !== 1'b0) begin
            bad++;
            $display("FAIL illegal_pre: drop=%b want 0", drop_err);
        end
        do_push(3'd2, 6'd40, 5'd0);
        total++;
        if (drop_err !== 1'b1 || pending !== 5'd0) begin
            bad++;
            $display("FAIL illegal_x: drop=%b pending=%0d want 1/0", drop_err, pending);
        end
        do_push(3'd1, 6'd0, 5'd30);
        total++;
        if (pending !== 5'd0) begin
            bad++;
            $display("FAIL illegal_y: pending=%0d want 0", pending);
        end
        settle(5);
        total++;
        if (render_count !== base || drop_err !== 1'b1) begin
            bad++;
            $display("FAIL illegal_norender: renders=%0d drop=%b want %0d/1", render_count, drop_err, base);
        end
        do_push(3'd7, 6'd39, 5'd29);
        wait_renders(base + 1, 20, "edge_legal_render");
        settle(20);
    endtask

    task automatic test_timeout();
        int base;
        apply_reset(2);
        eng_on = 1'b0;
        base   = render_count;
        do_push(3'd6, 6'd12, 5'd3);
        do_push(3'd2, 6'd0, 5'd0);
        wait_renders(base + 2, 60, "timeout_renders");
        total++;
        if (last_render_cyc - prev_render_cyc !== 10) begin
            bad++;
            $display("FAIL timeout_spacing: got %0d cycles want 10", last_render_cyc - prev_render_cyc);
        end
        total++;
        if (drop_rise_cyc - prev_render_cyc !== 9) begin
            bad++;
            $display("FAIL timeout_drop: drop_err rose %0d cycles after render want 9",
                     drop_rise_cyc - prev_render_cyc);
        end
        settle(15);
        total++;
        if (pending !== 5'd0 || drop_err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_end: pending=%0d drop=%b want 0/1", pending, drop_err);
        end
    endtask

    task automatic test_full();
        int base;
        bit ok;
        eng_on = 1'b0;
        base   = render_count;
        force_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            do_push(3'(i), 6'(i + 20), 5'(i + 5));
        end
        total++;
        if (cmd_ready !== 1'b0 || pending !== 5'd16 || render_count !== base) begin
            bad++;
            $display("FAIL full_state: ready=%b pending=%0d renders=%0d want 0/16/%0d",
                     cmd_ready, pending, render_count, base);
        end
        push_cmd(3'd3, 6'd3, 5'd3, 3, ok);
        total++;
        if (ok !== 1'b0 || pending !== 5'd16) begin
            bad++;
            $display("FAIL full_17th: accepted=%0d pending=%0d want 0/16", ok, pending);
        end
        eng_on     = 1'b1;
        force_busy = 1'b0;
        wait_renders(base + DEPTH, 400, "full_drain");
        settle(20);
        total++;
        if (pending !== 5'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL full_drained: pending=%0d busy=%b want 0/0", pending, busy);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        eng_on = 1'b0;
        apply_reset(2);
        force_busy = 1'b1;
        do_push(3'd1, 6'd5, 5'd6);
        do_push(3'd2, 6'd7, 5'd8);
        do_push(3'd3, 6'd9, 5'd10);
        do_push(3'd4, 6'd11, 5'd12);
        force_busy = 1'b0;
        @(posedge clk_100M);
        #1 force_busy = 1'b1;
        settle(4);
        total++;
        if (pending !== 5'd3 || render !== 1'b0) begin
            bad++;
            $display("FAIL mid_setup: pending=%0d render=%b want 3/0", pending, render);
        end
        apply_reset(2);
        total++;
        if (pending !== 5'd0 || render !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: pending=%0d render=%b ready=%b want 0/0/1", pending, render, cmd_ready);
        end
        base = render_count;
        settle(3);
        total++;
        if (render_count !== base) begin
            bad++;
            $display("FAIL mid_busy_hold: renders=%0d want %0d", render_count, base);
        end
        force_busy = 1'b0;
        do_push(3'd3, 6'd10, 5'd20);
        total++;
        if (render !== 1'b0) begin
            bad++;
            $display("FAIL mid_pre: render=%b want 0", render);
        end
        @(posedge clk_100M);
        #1;
        total++;
        if (render !== 1'b1) begin
            bad++;
            $display("FAIL mid_latency: render=%b want 1", render);
        end
        settle(15);
        total++;
        if (sb.size() !== 0 || pending !== 5'd0) begin
            bad++;
            $display("FAIL mid_end: scoreboard=%0d pending=%0d want 0/0", sb.size(), pending);
        end
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        cyc             = 0;
        render_count    = 0;
        last_render_cyc = 0;
        prev_render_cyc = 0;
        min_gap         = 1000;
        have_prev       = 1'b0;
        drop_rise_cyc   = 0;
        drop_prev       = 1'b0;
        exp_hold        = '0;
        reset           = 1'b1;
        cmd_valid       = 1'b0;
        cmd_sprite      = '0;
        cmd_x           = '0;
        cmd_y           = '0;
        force_busy      = 1'b0;
        eng_on          = 1'b0;

        test_reset();
        test_single();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_full();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
